// File: rtl/dbus_pkg.sv
// dbus_pkg: shared constants and state encodings for the dbus/UART bridge.
//   c_BYTEW         - width of every byte lane in the bridge
//   c_DEFAULT_DEPTH - default entries per byte FIFO
//   tx_state_t      - TX FIFO -> dbus issue FSM
//   rx_state_t      - dbus receive -> RX FIFO FSM
//   utx_state_t     - RX FIFO -> UART transmitter FSM
//   dbg_state_t     - all three FSM states packed for observation
package dbus_pkg;

  localparam int c_BYTEW         = 8;
  localparam int c_DEFAULT_DEPTH = 16;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_OFFER   = 2'd1,
    TX_SENDING = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_DRAIN = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    UTX_IDLE      = 2'd0,
    UTX_WAIT_BUSY = 2'd1,
    UTX_WAIT_DONE = 2'd2
  } utx_state_t;

  // Idle encodings are all zero, so a reset bridge reads 0 here.
  typedef struct packed {
    tx_state_t  tx;
    rx_state_t  rx;
    utx_state_t utx;
  } dbg_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO, first-word-fall-through head.
//   i_clock  - clock, posedge
//   i_reset  - asynchronous active-high reset (pointers and count cleared)
//   i_push   - write i_data this cycle (dropped if full and not popping)
//   i_pop    - remove head this cycle (ignored if empty)
//   i_data   - byte to write
//   o_data   - current head byte (valid while o_empty = 0)
//   o_full   - count == c_DEPTH
//   o_empty  - count == 0
//   o_count  - occupancy, updates the cycle after a push/pop
module byte_fifo
  import dbus_pkg::*;
#(
  parameter  int c_DEPTH = c_DEFAULT_DEPTH,
  localparam int c_AW    = $clog2(c_DEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [c_BYTEW-1:0] i_data,
  output logic [c_BYTEW-1:0] o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [c_AW:0]      o_count
);

  localparam logic [c_AW:0] c_FULLCOUNT = (c_AW + 1)'(c_DEPTH);

  logic [c_BYTEW-1:0] mem [c_DEPTH];
  logic [c_AW-1:0]    wr_ptr;
  logic [c_AW-1:0]    rd_ptr;
  logic [c_AW:0]      count;
  logic               do_push;
  logic               do_pop;

  assign o_full  = (count == c_FULLCOUNT);
  assign o_empty = (count == '0);
  assign o_count = count;
  assign o_data  = mem[rd_ptr];

  // A pop only happens with data present; a push into a full FIFO only
  // succeeds when the same cycle frees a slot.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clock) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_uart_bridge.sv
// dbus_uart_bridge: byte buffering between a UART byte interface and the
// dbus link engine.
//   UART side : i_uart_rx_data/i_uart_rx_valid (bytes in),
//               o_uart_tx_data/o_uart_tx_start/i_uart_tx_busy (bytes out)
//   dbus side : o_dbus_data/o_dbus_enable with i_dbus_busy,
//               i_dbus_receiving, i_dbus_reset (issue path);
//               i_dbus_avail/i_dbus_data/o_dbus_read (receive path)
//   status    : o_tx_count, o_rx_count, sticky o_tx_overflow, o_tx_lost,
//               o_rx_overflow (always 0), cleared by i_clear_flags
//   debug     : o_dbg_state, registered FSM states
//
// Handshakes:
//   dbus issue  - o_dbus_enable is held with stable o_dbus_data until the
//                 engine shows busy=1 with receiving=0 and reset=0; that
//                 cycle is the transfer, enable drops on the next edge.
//   dbus read   - while i_dbus_avail=1 and there is RX FIFO room the byte
//                 is taken and o_dbus_read pulses once; no further read is
//                 issued until avail has gone low.
//   UART TX     - o_uart_tx_start pulses one cycle with o_uart_tx_data
//                 stable; the next byte waits for busy to rise and fall.
//   UART RX     - every i_uart_rx_valid strobe is a byte; no backpressure.
module dbus_uart_bridge
  import dbus_pkg::*;
#(
  parameter int c_FIFODEPTH = c_DEFAULT_DEPTH,
  parameter int c_ADDRSIZE  = $clog2(c_FIFODEPTH)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [c_BYTEW-1:0] i_uart_rx_data,
  input  logic               i_uart_rx_valid,
  output logic [c_BYTEW-1:0] o_uart_tx_data,
  output logic               o_uart_tx_start,
  input  logic               i_uart_tx_busy,
  output logic [c_BYTEW-1:0] o_dbus_data,
  output logic               o_dbus_enable,
  input  logic               i_dbus_busy,
  input  logic               i_dbus_receiving,
  input  logic               i_dbus_reset,
  input  logic               i_dbus_avail,
  input  logic [c_BYTEW-1:0] i_dbus_data,
  output logic               o_dbus_read,
  input  logic               i_clear_flags,
  output logic [c_ADDRSIZE:0] o_tx_count,
  output logic [c_ADDRSIZE:0] o_rx_count,
  output logic               o_tx_overflow,
  output logic               o_rx_overflow,
  output logic               o_tx_lost,
  output dbg_state_t         o_dbg_state
);

  // ---------------------------------------------------------------- FIFOs
  logic               tx_push, tx_pop, tx_full, tx_empty;
  logic               rx_push, rx_pop, rx_full, rx_empty;
  logic [c_BYTEW-1:0] tx_head, rx_head;

  assign tx_push = i_uart_rx_valid;

  byte_fifo #(.c_DEPTH(c_FIFODEPTH)) u_tx_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (tx_push),
    .i_pop   (tx_pop),
    .i_data  (i_uart_rx_data),
    .o_data  (tx_head),
    .o_full  (tx_full),
    .o_empty (tx_empty),
    .o_count (o_tx_count)
  );

  byte_fifo #(.c_DEPTH(c_FIFODEPTH)) u_rx_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (rx_push),
    .i_pop   (rx_pop),
    .i_data  (i_dbus_data),
    .o_data  (rx_head),
    .o_full  (rx_full),
    .o_empty (rx_empty),
    .o_count (o_rx_count)
  );

  // ------------------------------------------------------- TX issue FSM
  tx_state_t          tx_state_q, tx_state_d;
  logic [c_BYTEW-1:0] dbus_data_q, dbus_data_d;
  logic               dbus_enable_q, dbus_enable_d;
  logic               tx_lost_set;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_state_q    <= TX_IDLE;
      dbus_data_q   <= '0;
      dbus_enable_q <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      dbus_data_q   <= dbus_data_d;
      dbus_enable_q <= dbus_enable_d;
    end
  end

  always_comb begin
    tx_state_d    = tx_state_q;
    dbus_data_d   = dbus_data_q;
    dbus_enable_d = dbus_enable_q;
    tx_pop        = 1'b0;
    tx_lost_set   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && !i_dbus_reset) begin
          dbus_data_d   = tx_head;
          dbus_enable_d = 1'b1;
          tx_state_d    = TX_OFFER;
        end
      end
      TX_OFFER: begin
        // Busy caused by an incoming frame is not an accept; the engine
        // comes back for the offered byte once its receive completes.
        if (i_dbus_busy && !i_dbus_receiving && !i_dbus_reset) begin
          dbus_enable_d = 1'b0;
          tx_pop        = 1'b1;
          tx_state_d    = TX_SENDING;
        end
      end
      TX_SENDING: begin
        // A link reset here kills the byte already handed over; it is
        // reported, not retried.
        if (i_dbus_reset) begin
          tx_lost_set = 1'b1;
        end
        if (!i_dbus_busy) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        dbus_enable_d = 1'b0;
        tx_state_d    = TX_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------ dbus read FSM
  rx_state_t rx_state_q, rx_state_d;
  logic      dbus_read_q, dbus_read_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_state_q  <= RX_IDLE;
      dbus_read_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      dbus_read_q <= dbus_read_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    dbus_read_d = 1'b0;
    rx_push     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // No room means no read: avail stays up and the engine stops
        // accepting frames, which is the receive-side backpressure.
        if (i_dbus_avail && !rx_full) begin
          rx_push     = 1'b1;
          dbus_read_d = 1'b1;
          rx_state_d  = RX_DRAIN;
        end
      end
      RX_DRAIN: begin
        // avail lingers for the engine's read latency; waiting for it to
        // fall keeps the same byte from being pushed twice.
        if (!i_dbus_avail) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ------------------------------------------------------ UART TX FSM
  utx_state_t         utx_state_q, utx_state_d;
  logic [c_BYTEW-1:0] uart_data_q, uart_data_d;
  logic               uart_start_q, uart_start_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      utx_state_q  <= UTX_IDLE;
      uart_data_q  <= '0;
      uart_start_q <= 1'b0;
    end else begin
      utx_state_q  <= utx_state_d;
      uart_data_q  <= uart_data_d;
      uart_start_q <= uart_start_d;
    end
  end

  always_comb begin
    utx_state_d  = utx_state_q;
    uart_data_d  = uart_data_q;
    uart_start_d = 1'b0;
    rx_pop       = 1'b0;
    case (utx_state_q)
      UTX_IDLE: begin
        if (!rx_empty && !i_uart_tx_busy) begin
          uart_data_d  = rx_head;
          uart_start_d = 1'b1;
          rx_pop       = 1'b1;
          utx_state_d  = UTX_WAIT_BUSY;
        end
      end
      // busy only rises the cycle after start, so wait for the rise
      // before looking for the fall.
      UTX_WAIT_BUSY: if (i_uart_tx_busy)  utx_state_d = UTX_WAIT_DONE;
      UTX_WAIT_DONE: if (!i_uart_tx_busy) utx_state_d = UTX_IDLE;
      default:       utx_state_d = UTX_IDLE;
    endcase
  end

  // ------------------------------------------------------- sticky flags
  logic tx_overflow_q, tx_lost_q;
  logic tx_ovf_set;

  assign tx_ovf_set = i_uart_rx_valid && tx_full && !tx_pop;

  // Set takes priority so an event in the clearing cycle is not lost.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_overflow_q <= 1'b0;
      tx_lost_q     <= 1'b0;
    end else begin
      if (tx_ovf_set)         tx_overflow_q <= 1'b1;
      else if (i_clear_flags) tx_overflow_q <= 1'b0;
      if (tx_lost_set)        tx_lost_q     <= 1'b1;
      else if (i_clear_flags) tx_lost_q     <= 1'b0;
    end
  end

  // ------------------------------------------------------------ outputs
  assign o_dbus_data     = dbus_data_q;
  assign o_dbus_enable   = dbus_enable_q;
  assign o_dbus_read     = dbus_read_q;
  assign o_uart_tx_data  = uart_data_q;
  assign o_uart_tx_start = uart_start_q;
  assign o_tx_overflow   = tx_overflow_q;
  assign o_tx_lost       = tx_lost_q;
  assign o_rx_overflow   = 1'b0;

  always_comb begin
    o_dbg_state     = '0;
    o_dbg_state.tx  = tx_state_q;
    o_dbg_state.rx  = rx_state_q;
    o_dbg_state.utx = utx_state_q;
  end

endmodule

// File: tb/tb_dbus_uart_bridge.sv
module tb_dbus_uart_bridge;
  import dbus_pkg::*;

  // ------------------------------------------------ clock / reset / DUT
  logic       i_clock = 1'b0;
  logic       i_reset;
  logic [7:0] i_uart_rx_data;
  logic       i_uart_rx_valid;
  logic [7:0] o_uart_tx_data;
  logic       o_uart_tx_start;
  logic       i_uart_tx_busy;
  logic [7:0] o_dbus_data;
  logic       o_dbus_enable;
  logic       i_dbus_busy;
  logic       i_dbus_receiving;
  logic       i_dbus_reset;
  logic       i_dbus_avail;
  logic [7:0] i_dbus_data;
  logic       o_dbus_read;
  logic       i_clear_flags;
  logic [4:0] o_tx_count;
  logic [4:0] o_rx_count;
  logic       o_tx_overflow;
  logic       o_rx_overflow;
  logic       o_tx_lost;
  dbg_state_t o_dbg_state;

  always #5 i_clock = ~i_clock;

  dbus_uart_bridge #(.c_FIFODEPTH(16)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_uart_rx_data   (i_uart_rx_data),
    .i_uart_rx_valid  (i_uart_rx_valid),
    .o_uart_tx_data   (o_uart_tx_data),
    .o_uart_tx_start  (o_uart_tx_start),
    .i_uart_tx_busy   (i_uart_tx_busy),
    .o_dbus_data      (o_dbus_data),
    .o_dbus_enable    (o_dbus_enable),
    .i_dbus_busy      (i_dbus_busy),
    .i_dbus_receiving (i_dbus_receiving),
    .i_dbus_reset     (i_dbus_reset),
    .i_dbus_avail     (i_dbus_avail),
    .i_dbus_data      (i_dbus_data),
    .o_dbus_read      (o_dbus_read),
    .i_clear_flags    (i_clear_flags),
    .o_tx_count       (o_tx_count),
    .o_rx_count       (o_rx_count),
    .o_tx_overflow    (o_tx_overflow),
    .o_rx_overflow    (o_rx_overflow),
    .o_tx_lost        (o_tx_lost),
    .o_dbg_state      (o_dbg_state)
  );

  // ------------------------------------------------ scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];       // bytes expected on dbus, in issue order
  logic [7:0] exp_uart_q[$];  // bytes expected on UART TX, in order
  int         read_pulses  = 0;
  int         start_pulses = 0;
  logic       uart_hold    = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_ovf;
    logic       clear;
  } push_vec_t;
  push_vec_t push_tab [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  // ------------------------------------------------ monitors and models
  // dbus issue monitor: every rising enable must carry the next expected byte.
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge i_clock);
      if (o_dbus_enable && !prev_en) begin
        if (exp_q.size() > 0) check("dbus_issue_data", 32'(o_dbus_data), 32'(exp_q.pop_front()));
        else check("dbus_unexpected_enable", 32'(o_dbus_enable), 32'd0);
      end
      prev_en = o_dbus_enable;
      if (o_dbus_read) read_pulses++;
      if (o_uart_tx_start) begin
        start_pulses++;
        if (exp_uart_q.size() > 0) check("uart_tx_data", 32'(o_uart_tx_data), 32'(exp_uart_q.pop_front()));
        else check("uart_unexpected_start", 32'(o_uart_tx_start), 32'd0);
      end
    end
  end

  // UART transmitter model: busy rises the cycle after start, lasts 3 cycles.
  initial begin
    logic prev_start;
    int   ucnt;
    prev_start = 1'b0;
    ucnt = 0;
    i_uart_tx_busy = 1'b0;
    forever begin
      @(posedge i_clock);
      #1;
      if (prev_start) ucnt = 3;
      else if (ucnt > 0) ucnt--;
      prev_start = o_uart_tx_start;
      i_uart_tx_busy = uart_hold || (ucnt > 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------ driver tasks
  // Wait for an offer, hold 2 cycles, accept with busy, check enable drops
  // one cycle later and the FIFO popped; optionally pulse dbus reset.
  task automatic dbus_accept(input logic [4:0] exp_cnt, input int hold, input bit lost);
    int n;
    n = 0;
    while (!o_dbus_enable && n < 60) begin
      step();
      n++;
    end
    check("enable_seen", 32'(o_dbus_enable), 32'd1);
    if (o_dbus_enable) begin
      repeat (2) step();
      check("enable_held", 32'(o_dbus_enable), 32'd1);
      i_dbus_busy = 1'b1;
      step();
      check("enable_drop_after_busy", 32'(o_dbus_enable), 32'd0);
      check("tx_count_after_pop", 32'(o_tx_count), 32'(exp_cnt));
      if (lost) begin
        i_dbus_reset = 1'b1;
        step();
        check("tx_lost_set", 32'(o_tx_lost), 32'd1);
        step();
        i_dbus_reset = 1'b0;
      end
      repeat (hold) step();
      i_dbus_busy = 1'b0;
    end
  endtask

  task automatic uart_push(input logic [7:0] b);
    i_uart_rx_valid = 1'b1;
    i_uart_rx_data  = b;
    step();
    i_uart_rx_valid = 1'b0;
  endtask

  // Engine presents a byte, keeps avail up 2 cycles after the read.
  task automatic rx_feed(input logic [7:0] b);
    int n;
    i_dbus_avail = 1'b1;
    i_dbus_data  = b;
    n = 0;
    while (!o_dbus_read && n < 40) begin
      step();
      n++;
    end
    check("rx_read_seen", 32'(o_dbus_read), 32'd1);
    repeat (2) step();
    i_dbus_avail = 1'b0;
    step();
  endtask

  // ------------------------------------------------ test sequence
  initial begin
    int n;
    int base;
    logic saw;

    for (int i = 0; i < 17; i++) begin
      push_tab[i].data      = 8'h10 + 8'(i);
      push_tab[i].exp_count = (i < 16) ? 5'(i + 1) : 5'd16;
      push_tab[i].exp_ovf   = (i == 16);
      push_tab[i].clear     = (i == 16);   // clear collides with the overflow
    end

    i_reset = 1'b1;
    i_uart_rx_data = '0; i_uart_rx_valid = 1'b0;
    i_dbus_busy = 1'b0; i_dbus_receiving = 1'b0; i_dbus_reset = 1'b0;
    i_dbus_avail = 1'b0; i_dbus_data = '0; i_clear_flags = 1'b0;
    repeat (3) @(posedge i_clock);
    #1;
    check("reset_enable", 32'(o_dbus_enable), 32'd0);
    check("reset_tx_count", 32'(o_tx_count), 32'd0);
    check("reset_rx_count", 32'(o_rx_count), 32'd0);
    check("reset_flags", 32'({o_tx_overflow, o_rx_overflow, o_tx_lost}), 32'd0);
    check("reset_strobes", 32'({o_dbus_read, o_uart_tx_start}), 32'd0);
    check("reset_dbg_state", 32'(o_dbg_state), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    step();

    // --- two bytes from UART issued in order, one episode each
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    uart_push(8'hA5);
    uart_push(8'h3C);
    check("tx_count_two", 32'(o_tx_count), 32'd2);
    dbus_accept(5'd1, 3, 1'b0);
    dbus_accept(5'd0, 3, 1'b0);
    repeat (10) step();
    check("dbus_queue_drained", 32'(exp_q.size()), 32'd0);
    check("enable_idle", 32'(o_dbus_enable), 32'd0);

    // --- one received byte goes to UART TX
    base = read_pulses;
    n = start_pulses;
    exp_uart_q.push_back(8'h7E);
    i_dbus_avail = 1'b1;
    i_dbus_data  = 8'h7E;
    step();
    check("rx_read_pulse", 32'(o_dbus_read), 32'd1);
    check("rx_count_one", 32'(o_rx_count), 32'd1);
    step();
    check("rx_read_single", 32'(o_dbus_read), 32'd0);
    check("uart_start", 32'(o_uart_tx_start), 32'd1);
    check("uart_data", 32'(o_uart_tx_data), 32'h7E);
    check("rx_count_zero", 32'(o_rx_count), 32'd0);
    step();
    i_dbus_avail = 1'b0;
    repeat (12) step();
    check("rx_read_total", 32'(read_pulses - base), 32'd1);
    check("uart_start_total", 32'(start_pulses - n), 32'd1);

    // --- 17 pushes while the engine is busy receiving (table driven)
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h99);
    i_dbus_busy = 1'b1;
    i_dbus_receiving = 1'b1;
    for (int i = 0; i < 17; i++) begin
      i_clear_flags = push_tab[i].clear;
      uart_push(push_tab[i].data);
      i_clear_flags = 1'b0;
      check($sformatf("fill_count_%0d", i), 32'(o_tx_count), 32'(push_tab[i].exp_count));
      check($sformatf("fill_ovf_%0d", i), 32'(o_tx_overflow), 32'(push_tab[i].exp_ovf));
    end
    check("offer_held_while_receiving", 32'(o_dbus_enable), 32'd1);
    i_clear_flags = 1'b1;
    step();
    i_clear_flags = 1'b0;
    check("ovf_cleared", 32'(o_tx_overflow), 32'd0);
    // accept and push in the same cycle while full
    i_dbus_receiving = 1'b0;
    i_uart_rx_valid = 1'b1;
    i_uart_rx_data  = 8'h99;
    step();
    i_uart_rx_valid = 1'b0;
    check("full_pushpop_enable", 32'(o_dbus_enable), 32'd0);
    check("full_pushpop_count", 32'(o_tx_count), 32'd16);
    check("full_pushpop_no_ovf", 32'(o_tx_overflow), 32'd0);
    repeat (2) step();
    i_dbus_busy = 1'b0;
    for (int k = 0; k < 16; k++) dbus_accept(5'(15 - k), 1, 1'b0);
    repeat (20) step();
    check("fill_queue_drained", 32'(exp_q.size()), 32'd0);
    check("no_17th_issue", 32'(o_dbus_enable), 32'd0);

    // --- RX backpressure with UART held busy
    uart_hold = 1'b1;
    base = read_pulses;
    for (int i = 0; i < 16; i++) begin
      exp_uart_q.push_back(8'h80 + 8'(i));
      rx_feed(8'h80 + 8'(i));
    end
    exp_uart_q.push_back(8'hEE);
    check("rx_full_count", 32'(o_rx_count), 32'd16);
    check("rx_reads_16", 32'(read_pulses - base), 32'd16);
    n = start_pulses;
    i_dbus_avail = 1'b1;
    i_dbus_data  = 8'hEE;
    saw = 1'b0;
    repeat (12) begin
      step();
      if (o_dbus_read) saw = 1'b1;
    end
    check("no_read_when_full", 32'(saw), 32'd0);
    check("rx_still_full", 32'(o_rx_count), 32'd16);
    uart_hold = 1'b0;
    base = 0;
    while (!o_dbus_read && base < 60) begin
      step();
      base++;
    end
    check("read_after_uart_pop", 32'(o_dbus_read), 32'd1);
    check("uart_popped_first", 32'(start_pulses > n), 32'd1);
    repeat (2) step();
    i_dbus_avail = 1'b0;
    base = 0;
    while ((o_rx_count != 0 || exp_uart_q.size() != 0) && base < 800) begin
      step();
      base++;
    end
    check("rx_drained", 32'(o_rx_count), 32'd0);
    check("uart_queue_drained", 32'(exp_uart_q.size()), 32'd0);

    // --- dbus reset while sending: byte lost, next byte still goes
    check("tx_lost_clear_before", 32'(o_tx_lost), 32'd0);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    uart_push(8'h51);
    uart_push(8'h52);
    dbus_accept(5'd1, 2, 1'b1);
    dbus_accept(5'd0, 2, 1'b0);
    repeat (15) step();
    check("lost_not_reissued", 32'(exp_q.size()), 32'd0);
    check("tx_lost_sticky", 32'(o_tx_lost), 32'd1);

    // --- asynchronous reset in the middle of an offer
    exp_q.push_back(8'h66);
    uart_push(8'h66);
    uart_push(8'h67);
    n = 0;
    while (!o_dbus_enable && n < 20) begin
      step();
      n++;
    end
    check("offer_before_reset", 32'(o_dbus_enable), 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check("reset_drops_enable", 32'(o_dbus_enable), 32'd0);
    check("reset_counts", 32'({o_tx_count, o_rx_count}), 32'd0);
    check("reset_clears_flags", 32'({o_tx_overflow, o_rx_overflow, o_tx_lost}), 32'd0);
    exp_q.delete();
    @(negedge i_clock);
    i_reset = 1'b0;
    repeat (10) step();
    check("post_reset_idle", 32'(o_dbus_enable), 32'd0);
    check("post_reset_tx_count", 32'(o_tx_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbus_uart_bridge.md
Name: dbus_uart_bridge

Overview:
- Byte-buffering stage between the UART byte interface and the dbus link engine.
- Host bytes from UART RX go into a TX FIFO and are issued to dbus one at a time with its enable/busy handshake.
- Bytes the engine receives (avail/read) go into an RX FIFO and are handed to UART TX.
- Provides backpressure both ways and sticky error flags.

Parameters:
- c_FIFODEPTH, 16, entries per FIFO; power of two, at least 2.
- c_ADDRSIZE, $clog2(c_FIFODEPTH), derived pointer width; count width is c_ADDRSIZE+1.

Ports:
- i_clock  in  1  system clock; all logic on posedge.
- i_reset  in  1  asynchronous, active-high reset.
- i_uart_rx_data  in  8  byte from UART receiver.
- i_uart_rx_valid  in  1  one-cycle strobe: i_uart_rx_data valid.
- o_uart_tx_data  out  8  byte to UART transmitter; stable while o_uart_tx_start is high.
- o_uart_tx_start  out  1  one-cycle strobe: start UART transmission.
- i_uart_tx_busy  in  1  UART transmitter busy; asserts the cycle after start.
- o_dbus_data  out  8  byte offered to dbus engine.
- o_dbus_enable  out  1  request to dbus engine to send o_dbus_data.
- i_dbus_busy  in  1  engine busy (TX, RX or reset).
- i_dbus_receiving  in  1  engine is receiving.
- i_dbus_reset  in  1  engine in timeout/reset sequence.
- i_dbus_avail  in  1  engine holds a received byte.
- i_dbus_data  in  8  received byte.
- o_dbus_read  out  1  one-cycle strobe: acknowledge received byte.
- i_clear_flags  in  1  clears sticky flags.
- o_tx_count  out  c_ADDRSIZE+1  TX FIFO occupancy.
- o_rx_count  out  c_ADDRSIZE+1  RX FIFO occupancy.
- o_tx_overflow  out  1  sticky: UART byte dropped because TX FIFO was full.
- o_rx_overflow  out  1  reserved; always 0. The RX path backpressures instead of dropping.
- o_tx_lost  out  1  sticky: dbus reset occurred while a byte was in flight.

Behaviour:
- Reset:
  - All outputs are registered and read 0.
  - Both FIFOs are empty; both FSMs are in IDLE.
  - Reset asserted mid-transfer drops o_dbus_enable immediately. The in-flight byte is discarded.
- FIFO rules, both FIFOs:
  - Push while full without a same-cycle pop: the byte is dropped.
  - Push and pop in the same cycle while full: both succeed; count is unchanged.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo c_FIFODEPTH.
- TX FSM:
  - IDLE: when the TX FIFO is non-empty and i_dbus_reset=0, load o_dbus_data from the head and set o_dbus_enable=1. Go to OFFER.
  - OFFER: hold data and enable stable.
    - If i_dbus_busy=1 and i_dbus_receiving=0 and i_dbus_reset=0: the byte is accepted. Next cycle, enable=0 and the head is popped. Go to SENDING.
    - If busy rises with receiving=1: keep offering. The engine retries after the receive completes.
  - SENDING: wait for i_dbus_busy=0, then go to IDLE. Minimum gap between successive enables is 1 cycle of busy low.
  - i_dbus_reset=1 in SENDING: set o_tx_lost. Stay until busy=0. The byte is not re-sent.
- RX FSM:
  - IDLE: when i_dbus_avail=1 and the RX FIFO is not full, push i_dbus_data and pulse o_dbus_read for exactly 1 cycle. Go to DRAIN.
  - DRAIN: wait for i_dbus_avail=0, then go to IDLE. This prevents a double push during the engine's 2-cycle read latency.
  - RX FIFO full: no read is issued. avail stays high and the engine refuses further bytes (link-level backpressure).
- UART TX FSM:
  - IDLE: when the RX FIFO is non-empty and i_uart_tx_busy=0, present the head, pulse o_uart_tx_start, pop. Go to WAIT.
  - WAIT: wait for busy=1, then busy=0, then go to IDLE.
- UART RX: every i_uart_rx_valid pushes to the TX FIFO. If it is full with no same-cycle pop, set o_tx_overflow.
- Flags:
  - i_clear_flags clears the sticky flags.
  - If a set condition and clear occur in the same cycle, set wins.
- Counts update the cycle after a push/pop.

Decomposition:
- Package dbus_pkg holds:
  - byte width constant (8);
  - TX/RX/UART state encodings (localparam enums);
  - default FIFO depth.
- One sub-module byte_fifo(c_DEPTH): synchronous FIFO with push, pop, data_in, data_out (head, first-word-fall-through), full, empty, count, and the same async active-high reset.
- The bridge instantiates byte_fifo twice.

Test Plan:
- Push 0xA5, then 0x3C via i_uart_rx_valid; the dbus model raises busy 2 cycles after enable. Required: o_dbus_data=0xA5 then 0x3C in order, one enable episode each, and enable drops 1 cycle after busy is seen.
- Dbus model presents avail=1 with data 0x7E. Required: one o_dbus_read pulse, rx_count=1, then o_uart_tx_start with o_uart_tx_data=0x7E.
- Push 17 bytes with c_FIFODEPTH=16 while the dbus model holds busy. Required: tx_count=16, o_tx_overflow=1, the 17th byte is never issued.
- Hold UART busy, then feed 16 received bytes followed by a 17th avail. Required: no read for the 17th until a UART pop; avail stays high meanwhile.
- Raise i_dbus_reset during SENDING. Required: o_tx_lost=1, the next FIFO byte is issued after busy=0, and the lost byte is not re-issued.
- Assert i_reset mid-OFFER. Required: o_dbus_enable=0 in the same cycle, counts=0, all flags 0.
